// File: rtl/fft_uart_pkg.sv
// ============================================================================
// Module : fft_uart_pkg
// Brief  : Shared state encoding, header default and sizing helpers for the
//          FFT-result-to-UART frame sequencer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package fft_uart_pkg;

    typedef enum logic [9:0] {
        S_IDLE     = 10'b00_0000_0001,
        S_HDR      = 10'b00_0000_0010,
        S_WAIT_HDR = 10'b00_0000_0100,
        S_RD       = 10'b00_0000_1000,
        S_LATCH    = 10'b00_0001_0000,
        S_SEND     = 10'b00_0010_0000,
        S_WAIT     = 10'b00_0100_0000,
        S_CHK      = 10'b00_1000_0000,
        S_WAIT_CHK = 10'b01_0000_0000,
        S_FIN      = 10'b10_0000_0000
    } state_t;

    localparam logic [7:0] C_HDR_BYTE_DEF = 8'hAA;

    function automatic int unsigned bytes_per_word(input int unsigned data_w);
        return data_w / 8;
    endfunction

    // Byte index needs at least one bit even for single-byte words.
    function automatic int unsigned idx_width(input int unsigned nbytes);
        return (nbytes > 1) ? $clog2(nbytes) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fft_uart_frame_sched_word_byte_sel.sv
// ============================================================================
// Module : word_byte_sel
// Brief  : Combinational selector returning byte idx_i of a RAM word
//          (idx 0 = least significant byte).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module word_byte_sel
    import fft_uart_pkg::*;
#(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned IDX_W  = 2
) (
    input  logic [DATA_W-1:0] word_i,
    input  logic [IDX_W-1:0]  idx_i,
    output logic [7:0]        byte_o
);

    localparam int unsigned C_BYTES = bytes_per_word(DATA_W);

    always_comb begin
        byte_o = 8'h00;
        for (int unsigned b = 0; b < C_BYTES; b++) begin
            if (idx_i == IDX_W'(b)) begin
                byte_o = word_i[8*b +: 8];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fft_uart_frame_sched.sv
// ============================================================================
// Module : fft_uart_frame_sched
// Brief  : Streams the FFT result RAM to the UART transmitter as a header
//          byte followed by every word MSB-first, one byte per tx_done_i.
//          Define FFT_UART_CHKSUM_EN to append an XOR checksum byte.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module fft_uart_frame_sched
    import fft_uart_pkg::*;
#(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned N_POINTS = 1024,
    parameter logic [7:0]  HDR_BYTE = C_HDR_BYTE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              rd_en_o,
    output logic [ADDR_W-1:0] rd_addr_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              tx_en_o,
    output logic [7:0]        tx_data_o,
    input  logic              tx_done_i
);

    localparam int unsigned       C_BYTES     = bytes_per_word(DATA_W);
    localparam int unsigned       C_IDX_W     = idx_width(C_BYTES);
    localparam logic [ADDR_W-1:0] C_LAST_ADDR = ADDR_W'(N_POINTS - 1);
    localparam logic [C_IDX_W-1:0] C_IDX_MSB  = C_IDX_W'(C_BYTES - 1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q,  addr_d;
    logic [C_IDX_W-1:0]  idx_q,   idx_d;
    logic [DATA_W-1:0]   word_q,  word_d;
    logic [7:0]          w_sel_byte;
`ifdef FFT_UART_CHKSUM_EN
    logic [7:0]          chk_q,   chk_d;
`endif

    word_byte_sel #(
        .DATA_W (DATA_W),
        .IDX_W  (C_IDX_W)
    ) u_byte_sel (
        .word_i (word_q),
        .idx_i  (idx_q),
        .byte_o (w_sel_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            idx_q   <= '0;
            word_q  <= '0;
`ifdef FFT_UART_CHKSUM_EN
            chk_q   <= 8'h00;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
`ifdef FFT_UART_CHKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        idx_d     = idx_q;
        word_d    = word_q;
`ifdef FFT_UART_CHKSUM_EN
        chk_d     = chk_q;
`endif
        busy_o    = 1'b1;
        done_o    = 1'b0;
        rd_en_o   = 1'b0;
        rd_addr_o = addr_q;
        tx_en_o   = 1'b0;
        tx_data_o = 8'h00;

        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    state_d = S_HDR;
                end
            end
            S_HDR: begin
                tx_en_o   = 1'b1;
                tx_data_o = HDR_BYTE;
`ifdef FFT_UART_CHKSUM_EN
                chk_d     = 8'h00;
`endif
                state_d   = S_WAIT_HDR;
            end
            S_WAIT_HDR: begin
                tx_data_o = HDR_BYTE;
                if (tx_done_i) begin
                    state_d = S_RD;
                end
            end
            S_RD: begin
                rd_en_o = 1'b1;
                state_d = S_LATCH;
            end
            S_LATCH: begin
                word_d  = rd_data_i;
                idx_d   = C_IDX_MSB;
                state_d = S_SEND;
            end
            S_SEND: begin
                tx_en_o   = 1'b1;
                tx_data_o = w_sel_byte;
`ifdef FFT_UART_CHKSUM_EN
                chk_d     = chk_q ^ w_sel_byte;
`endif
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                // Word register and index stay put here, so the byte holds.
                tx_data_o = w_sel_byte;
                if (tx_done_i) begin
                    if (idx_q != '0) begin
                        idx_d   = idx_q - 1'b1;
                        state_d = S_SEND;
                    end else if (addr_q != C_LAST_ADDR) begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_RD;
                    end else begin
`ifdef FFT_UART_CHKSUM_EN
                        state_d = S_CHK;
`else
                        state_d = S_FIN;
`endif
                    end
                end
            end
`ifdef FFT_UART_CHKSUM_EN
            S_CHK: begin
                tx_en_o   = 1'b1;
                tx_data_o = chk_q;
                state_d   = S_WAIT_CHK;
            end
            S_WAIT_CHK: begin
                tx_data_o = chk_q;
                if (tx_done_i) begin
                    state_d = S_FIN;
                end
            end
`endif
            S_FIN: begin
                busy_o  = 1'b0;
                done_o  = 1'b1;
                addr_d  = '0;
                state_d = S_IDLE;
            end
            default: begin
                busy_o  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_fft_uart_frame_sched.sv
// ============================================================================
// Module : tb_fft_uart_frame_sched
// Brief  : Self-checking bench: DUT A (16-bit words, 4 points) and DUT B
//          (32-bit word, 1 point) against a RAM/transmitter model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fft_uart_frame_sched;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_a, start_b, tx_done_a, tx_done_b;
    logic        busy_a, done_a, rd_en_a, tx_en_a;
    logic [1:0]  rd_addr_a;
    logic [15:0] rd_data_a;
    logic [7:0]  tx_data_a;
    logic        busy_b, done_b, rd_en_b, tx_en_b;
    logic [0:0]  rd_addr_b;
    logic [31:0] rd_data_b;
    logic [7:0]  tx_data_b;

    fft_uart_frame_sched #(.DATA_W(16), .ADDR_W(2), .N_POINTS(4), .HDR_BYTE(8'hAA)) dut_a (
        .clk(clk), .rst(rst), .start_i(start_a), .busy_o(busy_a), .done_o(done_a),
        .rd_en_o(rd_en_a), .rd_addr_o(rd_addr_a), .rd_data_i(rd_data_a),
        .tx_en_o(tx_en_a), .tx_data_o(tx_data_a), .tx_done_i(tx_done_a));

    fft_uart_frame_sched #(.DATA_W(32), .ADDR_W(1), .N_POINTS(1), .HDR_BYTE(8'hAA)) dut_b (
        .clk(clk), .rst(rst), .start_i(start_b), .busy_o(busy_b), .done_o(done_b),
        .rd_en_o(rd_en_b), .rd_addr_o(rd_addr_b), .rd_data_i(rd_data_b),
        .tx_en_o(tx_en_b), .tx_data_o(tx_data_b), .tx_done_i(tx_done_b));

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Per-DUT model state (index 0 = A, 1 = B)
    int         m_busy[2], m_cnt[2], m_done_cyc[2];
    logic [7:0] m_cur[2];
    logic [7:0] got[2][64];
    int         gap[2][64];
    int         got_n[2], raddr[2][16], raddr_n[2], done_n[2], prv_addr[2];
    bit         prv_rd[2], spur[2], lat_rand[2];
    logic [15:0] ram_a[4];
    logic [31:0] ram_b;
    logic [63:0] exp_w[4];

`ifdef FFT_UART_CHKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif
    localparam int FL_A = 1 + 4*2 + CK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // Transmitter + RAM-timing model for one DUT, evaluated once per negedge.
    task automatic xmit(input int k, input logic en, input logic [7:0] data, input logic rden,
                        input int ra, input logic busy, input logic done, output logic d);
        d = 1'b0;
        if (rst) begin
            m_busy[k] = 0;
            prv_rd[k] = 1'b0;
        end else begin
            if (spur[k] && m_busy[k] == 0 && (rden || prv_rd[k] || !busy)) d = 1'b1;
            if (m_busy[k] != 0) begin
                chk($sformatf("tx_en_spacing%0d", k), {63'd0, en}, 64'd0);
                chk($sformatf("tx_data_hold%0d", k), {56'd0, data}, {56'd0, m_cur[k]});
                m_cnt[k]--;
                if (m_cnt[k] == 0) begin
                    d = 1'b1;
                    m_busy[k] = 0;
                    m_done_cyc[k] = cyc;
                end
            end else if (en) begin
                if (got_n[k] < 64) begin
                    got[k][got_n[k]] = data;
                    gap[k][got_n[k]] = cyc - m_done_cyc[k];
                    got_n[k]++;
                end
                m_cur[k]  = data;
                m_busy[k] = 1;
                m_cnt[k]  = lat_rand[k] ? int'($urandom_range(1, 8)) : 20;
            end
            if (rden && raddr_n[k] < 16) begin
                raddr[k][raddr_n[k]] = ra;
                raddr_n[k]++;
            end
            if (done) done_n[k]++;
            prv_rd[k]   = rden;
            prv_addr[k] = ra;
        end
    endtask

    // RAM data is valid only in the cycle after the read strobe; noise otherwise.
    always @(negedge clk) begin
        cyc++;
        rd_data_a = prv_rd[0] ? ram_a[prv_addr[0]] : 16'($urandom);
        rd_data_b = prv_rd[1] ? ram_b : $urandom;
        xmit(0, tx_en_a, tx_data_a, rd_en_a, int'(rd_addr_a), busy_a, done_a, tx_done_a);
        xmit(1, tx_en_b, tx_data_b, rd_en_b, int'(rd_addr_b), busy_b, done_b, tx_done_b);
    end

    task automatic clear_log(input int k);
        got_n[k] = 0;
        raddr_n[k] = 0;
        done_n[k] = 0;
    endtask

    task automatic wait_done(input int k, input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 2000 && !seen; n++) begin
            tick;
            if ((k == 0) ? done_a : done_b) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
    endtask

    // Expected frame: header, words MSB-first, optional XOR of payload bytes.
    task automatic check_frame(input int k, input int base, input int bw, input int np, input string tag);
        int fl = 1 + np*bw + CK;
        logic [7:0] e;
        logic [7:0] x = 8'h00;
        chk({tag, "_len"}, 64'(got_n[k]), 64'(base + fl));
        for (int i = 0; i < fl; i++) begin
            if (i == 0) e = 8'hAA;
            else if (i <= np*bw) begin
                e = 8'((exp_w[(i-1)/bw] >> (8*(bw - 1 - (i-1)%bw))) & 64'hFF);
                x = x ^ e;
            end else e = x;
            chk($sformatf("%s_byte%0d", tag, i), {56'd0, got[k][base+i]}, {56'd0, e});
            if (i > 0)
                chk($sformatf("%s_gap%0d", tag, i), 64'(gap[k][base+i]),
                    ((i-1) < np*bw && (i-1) % bw == 0) ? 64'd3 : 64'd1);
        end
    endtask

    task automatic load_exp_a;
        for (int i = 0; i < 4; i++) exp_w[i] = {48'd0, ram_a[i]};
    endtask

    initial begin
        bit hit;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; tx_done_a = 1'b0; tx_done_b = 1'b0;
        spur = '{1'b0, 1'b0}; lat_rand = '{1'b0, 1'b0};
        ram_a = '{16'h1234, 16'hABCD, 16'h0000, 16'hFFFF};
        ram_b = 32'h0102_0304;
        repeat (3) tick;
        chk("rst_busy", {63'd0, busy_a}, 64'd0);
        chk("rst_done", {63'd0, done_a}, 64'd0);
        chk("rst_tx_en", {63'd0, tx_en_a}, 64'd0);
        chk("rst_rd_en", {63'd0, rd_en_a}, 64'd0);
        chk("rst_tx_data", {56'd0, tx_data_a}, 64'd0);
        chk("rst_rd_addr", {62'd0, rd_addr_a}, 64'd0);
        chk("rst_busy_b", {63'd0, busy_b}, 64'd0);
        rst = 1'b0;
        tick;

        // Frame 1: fixed RAM, 20-cycle transmitter
        clear_log(0);
        load_exp_a;
        start_a = 1'b1; tick; start_a = 1'b0;
        chk("f1_busy", {63'd0, busy_a}, 64'd1);
        chk("f1_hdr_en", {63'd0, tx_en_a}, 64'd1);
        wait_done(0, "f1");
        check_frame(0, 0, 2, 4, "f1");
        chk("f1_done_cnt", 64'(done_n[0]), 64'd1);
        chk("f1_rd_cnt", 64'(raddr_n[0]), 64'd4);
        for (int i = 0; i < 4; i++) chk($sformatf("f1_rd_addr%0d", i), 64'(raddr[0][i]), 64'(i));

        // start in the done cycle is ignored, one cycle later it is accepted
        start_a = 1'b1; tick;
        chk("b2b_idle", {63'd0, busy_a}, 64'd0);
        chk("b2b_no_en", {63'd0, tx_en_a}, 64'd0);
        tick; start_a = 1'b0;
        chk("b2b_busy", {63'd0, busy_a}, 64'd1);
        chk("b2b_hdr", {56'd0, tx_data_a}, 64'hAA);

        // Frame 2: spurious tx_done in RD/LATCH/IDLE and a mid-frame start
        spur[0] = 1'b1;
        repeat (40) tick;
        start_a = 1'b1; tick; start_a = 1'b0;
        wait_done(0, "f2");
        check_frame(0, FL_A, 2, 4, "f2");
        chk("f2_done_cnt", 64'(done_n[0]), 64'd2);
        repeat (10) tick;
        chk("idle_spur_busy", {63'd0, busy_a}, 64'd0);
        chk("idle_spur_len", 64'(got_n[0]), 64'(2*FL_A));
        spur[0] = 1'b0;

        // Reset while waiting on the fifth byte
        clear_log(0);
        start_a = 1'b1; tick; start_a = 1'b0;
        hit = 1'b0;
        for (int n = 0; n < 2000 && !hit; n++) begin
            tick;
            if (got_n[0] >= 5) hit = 1'b1;
        end
        chk("mid_byte5_seen", {63'd0, hit}, 64'd1);
        repeat (3) tick;
        rst = 1'b1; tick; rst = 1'b0;
        chk("mid_rst_busy", {63'd0, busy_a}, 64'd0);
        chk("mid_rst_tx_en", {63'd0, tx_en_a}, 64'd0);
        chk("mid_rst_rd_en", {63'd0, rd_en_a}, 64'd0);
        chk("mid_rst_done", {63'd0, done_a}, 64'd0);
        repeat (25) tick;
        chk("mid_rst_no_done", 64'(done_n[0]), 64'd0);
        clear_log(0);
        start_a = 1'b1; tick; start_a = 1'b0;
        wait_done(0, "f3");
        check_frame(0, 0, 2, 4, "f3");

        // Random RAM contents and transmitter latency
        lat_rand[0] = 1'b1;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 4; i++) ram_a[i] = 16'($urandom);
            load_exp_a;
            clear_log(0);
            tick;
            start_a = 1'b1; tick; start_a = 1'b0;
            wait_done(0, $sformatf("rnd%0d", r));
            check_frame(0, 0, 2, 4, $sformatf("rnd%0d", r));
            chk($sformatf("rnd%0d_done_cnt", r), 64'(done_n[0]), 64'd1);
        end

        // DUT B: single 32-bit word
        exp_w[0] = {32'd0, ram_b};
        clear_log(1);
        start_b = 1'b1; tick; start_b = 1'b0;
        wait_done(1, "fb");
        check_frame(1, 0, 4, 1, "fb");
        chk("fb_done_cnt", 64'(done_n[1]), 64'd1);
        chk("fb_rd_cnt", 64'(raddr_n[1]), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
